// File: rtl/stage_region_capture_if.sv
// Pixel-stream, read-port and status signals of stage_region_capture.
// The master side (drawing engine / testbench) drives pixels and read addresses.
interface stage_region_capture_if;
  logic       start;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] colour;
  logic [6:0] rd_x;
  logic [5:0] rd_y;
  logic [8:0] rd_colour;
  logic       busy;
  logic       capture_done;
  logic [11:0] pixel_count;

  modport master (
    output start, plot, x, y, colour, rd_x, rd_y,
    input  rd_colour, busy, capture_done, pixel_count
  );

  modport slave (
    input  start, plot, x, y, colour, rd_x, rd_y,
    output rd_colour, busy, capture_done, pixel_count
  );
endinterface

// File: rtl/stage_region_capture.sv
// Captures the pixels drawn inside a fixed screen window into a local frame store.
// Optional idle watchdog on CAPTURE is enabled by defining CAPTURE_TIMEOUT_EN.
module stage_region_capture #(
  parameter int unsigned ORIGIN_X = 39,
  parameter int unsigned ORIGIN_Y = 39,
  parameter int unsigned WIN_W    = 80,
  parameter int unsigned WIN_H    = 40
) (
  input logic                   clk,
  input logic                   reset,
  stage_region_capture_if.slave bus
);

  localparam int unsigned DEPTH  = WIN_W * WIN_H;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [8:0] X_LO = 9'(ORIGIN_X);
  localparam logic [8:0] X_HI = 9'(ORIGIN_X + WIN_W - 1);
  localparam logic [8:0] Y_LO = 9'(ORIGIN_Y);
  localparam logic [8:0] Y_HI = 9'(ORIGIN_Y + WIN_H - 1);
  localparam logic [8:0] LAST_LX = 9'(WIN_W - 1);
  localparam logic [8:0] LAST_LY = 9'(WIN_H - 1);

  localparam logic [11:0] CNT_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [8:0]  rd_colour_q, rd_colour_d;

  logic [8:0] mem [DEPTH];

  logic [8:0]        x_w, y_w;
  logic [8:0]        lx, ly;
  logic              in_window;
  logic              accept;
  logic              last_local;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_ok;
  logic [ADDR_W-1:0] rd_addr;

`ifdef CAPTURE_TIMEOUT_EN
  // Timeout fires on the 4095th consecutive CAPTURE cycle without an accepted pixel.
  localparam logic [11:0] IDLE_LIMIT = 12'd4094;
  logic [11:0] idle_q, idle_d;
`endif

  // Window hit test and local addressing, all on 9-bit unsigned values.
  always_comb begin
    x_w        = {1'b0, bus.x};
    y_w        = {2'b00, bus.y};
    lx         = x_w - X_LO;
    ly         = y_w - Y_LO;
    in_window  = (x_w >= X_LO) && (x_w <= X_HI) && (y_w >= Y_LO) && (y_w <= Y_HI);
    accept     = (state_q == S_CAPTURE) && bus.plot && in_window;
    last_local = (lx == LAST_LX) && (ly == LAST_LY);
    wr_addr    = ADDR_W'(32'(ly) * WIN_W + 32'(lx));
  end

  always_comb begin
    rd_ok   = (32'(bus.rd_x) < WIN_W) && (32'(bus.rd_y) < WIN_H);
    rd_addr = ADDR_W'(32'(bus.rd_y) * WIN_W + 32'(bus.rd_x));
    // Out-of-range addresses hold the previous value so the output stays stable.
    rd_colour_d = rd_colour_q;
    if (rd_ok) begin
      rd_colour_d = mem[rd_addr];
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef CAPTURE_TIMEOUT_EN
    idle_d  = idle_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CAPTURE;
          count_d = '0;
`ifdef CAPTURE_TIMEOUT_EN
          idle_d  = '0;
`endif
        end
      end

      S_CAPTURE: begin
        if (accept) begin
          if (count_q != CNT_MAX) begin
            count_d = count_q + 12'd1;
          end
          if (last_local || (32'(count_d) >= DEPTH)) begin
            state_d = S_DONE;
          end
`ifdef CAPTURE_TIMEOUT_EN
          idle_d = '0;
        end else if (idle_q == IDLE_LIMIT) begin
          state_d = S_IDLE;
        end else begin
          idle_d = idle_q + 12'd1;
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rd_colour_q <= '0;
`ifdef CAPTURE_TIMEOUT_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_colour_q <= rd_colour_d;
`ifdef CAPTURE_TIMEOUT_EN
      idle_q      <= idle_d;
`endif
    end
  end

  // NOTE: the frame store has no reset; its contents are don't-care until written by a capture.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr] <= bus.colour;
    end
  end

  assign bus.busy         = (state_q == S_CAPTURE);
  assign bus.capture_done = (state_q == S_DONE);
  assign bus.pixel_count  = count_q;
  assign bus.rd_colour    = rd_colour_q;

endmodule

// File: tb/tb_stage_region_capture.sv
// Scoreboard bench for stage_region_capture: stimulus pushes expectations, a
// negedge monitor pops and compares status, read data and capture_done pulses.
module tb_stage_region_capture;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stage_region_capture_if bus();

  stage_region_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic        busy;
    logic [11:0] cnt;
    logic        chk_rd;
    logic [8:0]  rd;
    string       name;
  } st_exp_t;

  typedef struct {
    int unsigned due;
    logic [8:0]  rd;
    string       name;
  } rd_exp_t;

  typedef struct {
    int unsigned due;
    logic [11:0] cnt;
    string       name;
  } done_exp_t;

  st_exp_t   st_q[$];
  rd_exp_t   rd_q[$];
  done_exp_t done_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- monitor ----------------
  st_exp_t   m_st;
  rd_exp_t   m_rd;
  done_exp_t m_dn;

  always @(negedge clk) begin
    while (st_q.size() > 0 && st_q[0].due < cyc) begin
      m_st = st_q.pop_front();
      check({m_st.name, "_stale"}, 32'd0, 32'd1);
    end
    if (st_q.size() > 0 && st_q[0].due == cyc) begin
      m_st = st_q.pop_front();
      check({m_st.name, "_busy"}, 32'(bus.busy), 32'(m_st.busy));
      check({m_st.name, "_done"}, 32'(bus.capture_done), 32'd0);
      check({m_st.name, "_count"}, 32'(bus.pixel_count), 32'(m_st.cnt));
      if (m_st.chk_rd) check({m_st.name, "_rd"}, 32'(bus.rd_colour), 32'(m_st.rd));
    end

    while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
      m_rd = rd_q.pop_front();
      check({m_rd.name, "_stale"}, 32'd0, 32'd1);
    end
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      m_rd = rd_q.pop_front();
      check(m_rd.name, 32'(bus.rd_colour), 32'(m_rd.rd));
    end

    if (bus.capture_done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        m_dn = done_q.pop_front();
        check({m_dn.name, "_cycle"}, cyc, m_dn.due);
        check({m_dn.name, "_count"}, 32'(bus.pixel_count), 32'(m_dn.cnt));
      end
    end else if (done_q.size() > 0 && done_q[0].due <= cyc) begin
      m_dn = done_q.pop_front();
      check({m_dn.name, "_missed"}, 32'd0, 32'd1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "bench timeout");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int px, input int py, input logic [8:0] c);
    bus.plot   = 1'b1;
    bus.x      = 8'(px);
    bus.y      = 7'(py);
    bus.colour = c;
    tick();
    bus.plot   = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic expect_status(input string name, input logic b, input logic [11:0] cnt,
                               input logic chk_rd, input logic [8:0] rd);
    st_exp_t e;
    e.due = cyc; e.busy = b; e.cnt = cnt; e.chk_rd = chk_rd; e.rd = rd; e.name = name;
    st_q.push_back(e);
  endtask

  task automatic do_read(input string name, input int rx, input int ry, input logic [8:0] exp);
    rd_exp_t e;
    bus.rd_x = 7'(rx);
    bus.rd_y = 6'(ry);
    e.due = cyc + 1; e.rd = exp; e.name = name;
    rd_q.push_back(e);
  endtask

  task automatic expect_done(input string name, input logic [11:0] cnt);
    done_exp_t e;
    e.due = cyc; e.cnt = cnt; e.name = name;
    done_q.push_back(e);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.plot = 1'b0; bus.x = '0; bus.y = '0; bus.colour = '0;
    bus.rd_x = '0; bus.rd_y = '0;
    tick(); tick();
    expect_status("reset_state", 1'b0, 12'd0, 1'b1, 9'd0);
    tick();
    reset = 1'b0;
    tick();
    expect_status("idle_after_reset", 1'b0, 12'd0, 1'b0, 9'd0);

    // Full raster, colour = x.
    do_start();
    expect_status("raster_start", 1'b1, 12'd0, 1'b0, 9'd0);
    for (int yy = 39; yy <= 78; yy++)
      for (int xx = 39; xx <= 118; xx++)
        pix(xx, yy, 9'(xx));
    expect_done("raster_done", 12'd3200);
    do_read("raster_rd_5_0", 5, 0, 9'd44);
    tick();
    expect_status("raster_idle", 1'b0, 12'd3200, 1'b0, 9'd0);
    do_read("raster_rd_0_0", 0, 0, 9'd39);
    tick();
    do_read("raster_rd_79_39", 79, 39, 9'd118);
    tick(); tick();
    expect_status("raster_hold", 1'b0, 12'd3200, 1'b0, 9'd0);

    // Out-of-window and plot=0 pixels are dropped.
    do_start();
    expect_status("drop_start", 1'b1, 12'd0, 1'b0, 9'd0);
    pix(38, 39, 9'h111);
    pix(119, 50, 9'h111);
    pix(60, 79, 9'h111);
    pix(50, 38, 9'h111);
    bus.x = 8'd40; bus.y = 7'd40; bus.colour = 9'h1FF; bus.plot = 1'b0;
    tick();
    expect_status("drop_none_taken", 1'b1, 12'd0, 1'b0, 9'd0);
    do_read("drop_rd_1_1", 1, 1, 9'd40);
    tick();

    // 100 pixels, a start while busy, then more pixels.
    for (int i = 0; i < 100; i++)
      pix(39 + (i % 80), 39 + (i / 80), 9'(300 + i));
    expect_status("stream_100", 1'b1, 12'd100, 1'b0, 9'd0);
    do_start();
    expect_status("start_ignored", 1'b1, 12'd100, 1'b0, 9'd0);
    pix(50, 60, 9'd5);
    pix(51, 60, 9'd5);
    pix(52, 60, 9'd5);
    expect_status("stream_103", 1'b1, 12'd103, 1'b0, 9'd0);
    do_read("rd_during_wr_old", 0, 0, 9'd300);
    pix(39, 39, 9'h0AB);
    do_read("rd_after_wr_new", 0, 0, 9'h0AB);
    tick();
    expect_status("stream_104", 1'b1, 12'd104, 1'b0, 9'd0);
    pix(118, 78, 9'h1A5);
    expect_done("stream_done", 12'd105);
    pix(61, 61, 9'h1FF);
    expect_status("stream_idle", 1'b0, 12'd105, 1'b0, 9'd0);
    pix(60, 60, 9'h1FF);
    expect_status("idle_pixel_dropped", 1'b0, 12'd105, 1'b0, 9'd0);

    // Corner pixel as first pixel completes with count 1.
    do_start();
    expect_status("corner_start", 1'b1, 12'd0, 1'b0, 9'd0);
    pix(118, 78, 9'h0F0);
    expect_done("corner_first", 12'd1);
    do_read("corner_rd_79_39", 79, 39, 9'h0F0);
    tick();
    do_read("rd_79_38", 79, 38, 9'd118);
    tick();
    do_read("rd_5_0", 5, 0, 9'd305);
    tick();
    do_read("rd_20_1", 20, 1, 9'd59);
    tick();
    do_read("rd_19_1", 19, 1, 9'd399);
    tick();
    do_read("rd_1_1", 1, 1, 9'd381);
    tick();
    do_read("rd_11_21", 11, 21, 9'd5);
    tick();
    do_read("rd_21_21_idle_drop", 21, 21, 9'd60);
    tick();
    do_read("rd_22_22_done_drop", 22, 22, 9'd61);
    tick();

    // Asynchronous reset in the middle of a capture.
    do_start();
    for (int i = 0; i < 10; i++)
      pix(39 + i, 69, 9'(i));
    expect_status("pre_reset_10", 1'b1, 12'd10, 1'b0, 9'd0);
    do_read("pre_reset_rd", 5, 0, 9'd305);
    tick();
    tick();
    #1;
    reset = 1'b1;
    expect_status("reset_async", 1'b0, 12'd0, 1'b1, 9'd0);
    tick();
    bus.start = 1'b1;
    pix(40, 40, 9'd7);
    expect_status("reset_held", 1'b0, 12'd0, 1'b1, 9'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    tick();
    expect_status("reset_released", 1'b0, 12'd0, 1'b0, 9'd0);

    // Idle watchdog behaviour.
    do_start();
    pix(40, 70, 9'd1);
    pix(41, 70, 9'd1);
    expect_status("wd_count2", 1'b1, 12'd2, 1'b0, 9'd0);
    repeat (4094) tick();
    expect_status("wd_4094", 1'b1, 12'd2, 1'b0, 9'd0);
`ifdef CAPTURE_TIMEOUT_EN
    tick();
    expect_status("wd_fired", 1'b0, 12'd2, 1'b0, 9'd0);
    tick();
    expect_status("wd_idle", 1'b0, 12'd2, 1'b0, 9'd0);
`else
    repeat (5000 - 4094) tick();
    expect_status("no_wd_5000", 1'b1, 12'd2, 1'b0, 9'd0);
`endif

    tick(); tick();
    check("scoreboard_drained", 32'(st_q.size() + rd_q.size() + done_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
